// File: rtl/gamma_pkg.sv
// Shared types and defaults for the run-time programmable gamma LUT stage.
// One table bank is read by video while the other is loaded by the config master.
package gamma_pkg;

  localparam int DATA_W_DEF = 8;
  localparam bit VS_POL_DEF = 1'b1;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_e;

  // Identity entry for a flat table address {bank, index}: the value is the index.
  function automatic logic [DATA_W_DEF-1:0] identity_entry(input logic [DATA_W_DEF:0] flat_addr);
    return flat_addr[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/gamma_lut_dpram.sv
// Simple dual-port table RAM holding both LUT banks, addressed {bank, index}.
// One write port, one registered read port, written to map onto block RAM.
module gamma_lut_dpram
  import gamma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Pre_clk,
  input  logic              we,
  input  logic [DATA_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** (DATA_W + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Pre_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma LUT for one colour channel: identity init, shadow-bank load,
// and a bank swap committed only at frame start so the picture never tears.
module gamma_lut_ctrl
  import gamma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit VS_POL = VS_POL_DEF
) (
  input  logic              Pre_clk,
  input  logic              Pre_Rst,
  input  logic [DATA_W-1:0] Pre_Data,
  input  logic              Pre_DE,
  input  logic              Pre_Vsync,
  input  logic              Pre_Hsync,
  output logic [DATA_W-1:0] Post_Data,
  output logic              Post_DE,
  output logic              Post_Vsync,
  output logic              Post_Hsync,
  input  logic              Cfg_Valid,
  output logic              Cfg_Ready,
  input  logic [DATA_W-1:0] Cfg_Addr,
  input  logic [DATA_W-1:0] Cfg_Data,
  input  logic              Cfg_Last,
  input  logic              Bypass,
  output logic              Active_Bank,
  output logic              Swap_Pending
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W:0]   init_cnt_q;
  logic              init_last;
  logic              cfg_fire;
  logic              frame_start;
  logic              bypass_q;

  logic              ram_we;
  logic [DATA_W:0]   ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] lut_p1;

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              vs_p1;
  logic              hs_p1;
  logic              vs_prev;

  // Blanking forces zero; bypass passes the delayed raw pixel; otherwise the table value.
  function automatic logic [DATA_W-1:0] sel_pixel(
    input logic              de,
    input logic              byp,
    input logic [DATA_W-1:0] raw,
    input logic [DATA_W-1:0] lut
  );
    if (!de) begin
      return '0;
    end else if (byp) begin
      return raw;
    end else begin
      return lut;
    end
  endfunction

  assign init_last   = (init_cnt_q == {(DATA_W + 1){1'b1}});
  assign cfg_fire    = Cfg_Valid && Cfg_Ready;
  assign frame_start = (vs_p1 == VS_POL) && (vs_prev != VS_POL);

  always_ff @(posedge Pre_clk) begin
    if (Pre_Rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_last) state_d = LOAD;
      LOAD:    if (cfg_fire && Cfg_Last) state_d = PEND;
      PEND:    if (frame_start) state_d = LOAD;
      default: state_d = INIT;
    endcase
  end

  // INIT sweeps the flat {bank, index} space once, so both banks get identity.
  always_comb begin
    Cfg_Ready    = 1'b0;
    Swap_Pending = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = init_cnt_q;
    ram_wdata    = identity_entry(init_cnt_q);
    case (state_q)
      INIT: begin
        ram_we = 1'b1;
      end
      LOAD: begin
        Cfg_Ready = 1'b1;
        ram_we    = cfg_fire;
        ram_waddr = {~Active_Bank, Cfg_Addr};
        ram_wdata = Cfg_Data;
      end
      PEND: begin
        Swap_Pending = 1'b1;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Pre_clk) begin
    if (Pre_Rst) begin
      init_cnt_q <= '0;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Frame start during INIT is ignored; in LOAD only the bypass choice is refreshed.
  always_ff @(posedge Pre_clk) begin
    if (Pre_Rst) begin
      Active_Bank <= 1'b0;
      bypass_q    <= 1'b0;
    end else if (frame_start && (state_q != INIT)) begin
      bypass_q <= Bypass;
      if (state_q == PEND) begin
        Active_Bank <= ~Active_Bank;
      end
    end
  end

  gamma_lut_dpram #(
    .DATA_W (DATA_W)
  ) u_lut (
    .Pre_clk (Pre_clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   ({Active_Bank, Pre_Data}),
    .rdata   (lut_p1)
  );

  // Stage p1: table read in flight, raw pixel and syncs held alongside.
  always_ff @(posedge Pre_clk) begin
    data_p1 <= Pre_Data;
  end

  always_ff @(posedge Pre_clk) begin
    if (Pre_Rst) begin
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= ~VS_POL;
      vs_prev <= ~VS_POL;
    end else begin
      vld_p1  <= Pre_DE;
      hs_p1   <= Pre_Hsync;
      vs_p1   <= Pre_Vsync;
      vs_prev <= vs_p1;
    end
  end

  // Stage p2: output register.
  always_ff @(posedge Pre_clk) begin
    if (Pre_Rst) begin
      Post_Data  <= '0;
      Post_DE    <= 1'b0;
      Post_Vsync <= 1'b0;
      Post_Hsync <= 1'b0;
    end else begin
      Post_Data  <= sel_pixel(vld_p1, bypass_q, data_p1, lut_p1);
      Post_DE    <= vld_p1;
      Post_Vsync <= vs_p1;
      Post_Hsync <= hs_p1;
    end
  end

endmodule
